// File: rtl/alu_issue_arbiter_if.sv
// Requester, ALU and response signal bundle for alu_issue_arbiter.
// master is the arbiter's view; slave is the surrounding requesters, ALU and consumer.
interface alu_issue_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [4:0]        req0_opcode;
  logic [1:0]        req0_funct;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [TAG_W-1:0]  req0_tag;

  logic              req1_valid;
  logic              req1_ready;
  logic [4:0]        req1_opcode;
  logic [1:0]        req1_funct;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [TAG_W-1:0]  req1_tag;

  logic [4:0]        alu_opcode;
  logic [1:0]        alu_funct;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_out;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_id;
  logic [TAG_W-1:0]  resp_tag;
  logic              busy;

  modport master (
    input  req0_valid, req0_opcode, req0_funct, req0_a, req0_b, req0_tag,
    output req0_ready,
    input  req1_valid, req1_opcode, req1_funct, req1_a, req1_b, req1_tag,
    output req1_ready,
    output alu_opcode, alu_funct, alu_a, alu_b,
    input  alu_out,
    output resp_valid, resp_data, resp_id, resp_tag, busy,
    input  resp_ready
  );

  modport slave (
    output req0_valid, req0_opcode, req0_funct, req0_a, req0_b, req0_tag,
    input  req0_ready,
    output req1_valid, req1_opcode, req1_funct, req1_a, req1_b, req1_tag,
    input  req1_ready,
    input  alu_opcode, alu_funct, alu_a, alu_b,
    output alu_out,
    input  resp_valid, resp_data, resp_id, resp_tag, busy,
    output resp_ready
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters:
// issue register (S1) drives the ALU, response register (S2) captures its result.
module alu_issue_arbiter #(
  parameter int DATA_W    = 16,
  parameter int TAG_W     = 4,
  parameter bit PRIO_INIT = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_issue_arbiter_if.master bus
);

  logic              s1_valid_q, s1_valid_d;
  logic [4:0]        s1_opcode_q, s1_opcode_d;
  logic [1:0]        s1_funct_q, s1_funct_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d;
  logic [DATA_W-1:0] s1_b_q, s1_b_d;
  logic              s1_id_q, s1_id_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_id_q, resp_id_d;
  logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;

  logic              prio_q, prio_d;

  logic              s2_free;
  logic              s1_take;
  logic              grant;
  logic              take0;
  logic              take1;

  always_comb begin
    s2_free = !resp_valid_q || bus.resp_ready;
    s1_take = !s1_valid_q || s2_free;
    if (bus.req0_valid && bus.req1_valid) grant = prio_q;
    else                                  grant = bus.req1_valid;
    take0 = s1_take && !grant && bus.req0_valid;
    take1 = s1_take &&  grant && bus.req1_valid;
  end

  // rst_n only masks the outputs; the flops never see it on their D path
  assign bus.req0_ready = rst_n && take0;
  assign bus.req1_ready = rst_n && take1;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_opcode_d  = s1_opcode_q;
    s1_funct_d   = s1_funct_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_id_d      = s1_id_q;
    s1_tag_d     = s1_tag_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    resp_tag_d   = resp_tag_q;
    prio_d       = prio_q;

    if (s1_take) s1_valid_d = take0 || take1;
    if (take0) begin
      s1_opcode_d = bus.req0_opcode;
      s1_funct_d  = bus.req0_funct;
      s1_a_d      = bus.req0_a;
      s1_b_d      = bus.req0_b;
      s1_id_d     = 1'b0;
      s1_tag_d    = bus.req0_tag;
      prio_d      = 1'b1;
    end else if (take1) begin
      s1_opcode_d = bus.req1_opcode;
      s1_funct_d  = bus.req1_funct;
      s1_a_d      = bus.req1_a;
      s1_b_d      = bus.req1_b;
      s1_id_d     = 1'b1;
      s1_tag_d    = bus.req1_tag;
      prio_d      = 1'b0;
    end

    if (s1_valid_q && s2_free) begin
      resp_valid_d = 1'b1;
      resp_data_d  = bus.alu_out;
      resp_id_d    = s1_id_q;
      resp_tag_d   = s1_tag_q;
    end else if (bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_opcode_q  <= '0;
      s1_funct_q   <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_id_q      <= 1'b0;
      s1_tag_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      resp_tag_q   <= '0;
      prio_q       <= PRIO_INIT;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_opcode_q  <= s1_opcode_d;
      s1_funct_q   <= s1_funct_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_id_q      <= s1_id_d;
      s1_tag_q     <= s1_tag_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      resp_tag_q   <= resp_tag_d;
      prio_q       <= prio_d;
    end
  end

  // ALU sees zeros whenever the issue stage is empty
  assign bus.alu_opcode = s1_valid_q ? s1_opcode_q : '0;
  assign bus.alu_funct  = s1_valid_q ? s1_funct_q  : '0;
  assign bus.alu_a      = s1_valid_q ? s1_a_q      : '0;
  assign bus.alu_b      = s1_valid_q ? s1_b_q      : '0;

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_tag   = resp_tag_q;
  assign bus.busy       = s1_valid_q || resp_valid_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed scenarios plus randomized traffic
// against an in-order two-slot queue model with a behavioural ALU.
module tb_alu_issue_arbiter;
  localparam int DATA_W    = 16;
  localparam int TAG_W     = 4;
  localparam bit PRIO_INIT = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  alu_issue_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  alu_issue_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .PRIO_INIT(PRIO_INIT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] alu_f(input logic [4:0] op, input logic [1:0] fn,
                                              input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (op == 5'b11011) begin
      case (fn)
        2'd0:    return a + b;
        2'd1:    return b - a;
        2'd2:    return a & b;
        default: return a | b;
      endcase
    end
    return a ^ {b[7:0], b[15:8]} ^ DATA_W'(op);
  endfunction

  assign bus.alu_out = alu_f(bus.alu_opcode, bus.alu_funct, bus.alu_a, bus.alu_b);

  // Reference: accepted ops queue in order; an op is visible as a response
  // from the second edge after its acceptance. Two ops in flight means the
  // block is full and only a consumer pop lets a new one in.
  typedef struct {
    int                cyc;
    logic              id;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t mq[$];
  int   now = 0;
  logic ptr_m = PRIO_INIT;
  logic acc0, acc1;

  logic [4:0]        r_op [2];
  logic [1:0]        r_fn [2];
  logic [DATA_W-1:0] r_a  [2];
  logic [DATA_W-1:0] r_b  [2];
  logic [TAG_W-1:0]  r_tag[2];
  logic              pend [2];

  function automatic logic m_resp_valid();
    return (mq.size() > 0) && (now >= mq[0].cyc + 2);
  endfunction

  function automatic logic m_grant1();
    return (bus.req0_valid && bus.req1_valid) ? ptr_m : bus.req1_valid;
  endfunction

  function automatic logic m_ready(input int i);
    logic room;
    room = rst_n && ((mq.size() < 2) || bus.resp_ready);
    if (i == 0) return room && bus.req0_valid && !m_grant1();
    return room && bus.req1_valid && m_grant1();
  endfunction

  task automatic model_reset();
    mq.delete();
    ptr_m = PRIO_INIT;
  endtask

  task automatic tick();
    exp_t e;
    acc0 = m_ready(0);
    acc1 = m_ready(1);
    if (m_resp_valid() && bus.resp_ready) void'(mq.pop_front());
    if (acc0) begin
      e.cyc = now; e.id = 1'b0; e.tag = bus.req0_tag;
      e.data = alu_f(bus.req0_opcode, bus.req0_funct, bus.req0_a, bus.req0_b);
      mq.push_back(e);
      ptr_m = 1'b1;
    end
    if (acc1) begin
      e.cyc = now; e.id = 1'b1; e.tag = bus.req1_tag;
      e.data = alu_f(bus.req1_opcode, bus.req1_funct, bus.req1_a, bus.req1_b);
      mq.push_back(e);
      ptr_m = 1'b0;
    end
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic drive_req(input int i, input logic v, input logic [4:0] op, input logic [1:0] fn,
                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic [TAG_W-1:0] tag);
    if (i == 0) begin
      bus.req0_valid = v; bus.req0_opcode = op; bus.req0_funct = fn;
      bus.req0_a = a; bus.req0_b = b; bus.req0_tag = tag;
    end else begin
      bus.req1_valid = v; bus.req1_opcode = op; bus.req1_funct = fn;
      bus.req1_a = a; bus.req1_b = b; bus.req1_tag = tag;
    end
  endtask

  task automatic test_reset();
    drive_req(0, 1'b0, '0, '0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0, '0, '0);
    bus.resp_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.resp_valid, bus.busy, bus.req0_ready, bus.req1_ready} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b expected 0000",
               {bus.resp_valid, bus.busy, bus.req0_ready, bus.req1_ready});
    end
    vectors++;
    if ({bus.alu_opcode, bus.alu_funct, bus.alu_a, bus.alu_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_alu: got %h expected 0", {bus.alu_opcode, bus.alu_funct, bus.alu_a, bus.alu_b});
    end
    vectors++;
    if ({bus.resp_data, bus.resp_id, bus.resp_tag} !== '0) begin
      miscompares++;
      $display("FAIL reset_resp: got %h expected 0", {bus.resp_data, bus.resp_id, bus.resp_tag});
    end
    model_reset();
    @(posedge clk); #1;
    bus.req0_valid = 1'b1;
    #2;
    vectors++;
    if (bus.req0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_held: got %b expected 0", bus.req0_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_ready: got %b expected 1", bus.req0_ready);
    end
    bus.req1_valid = 1'b1;
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== {PRIO_INIT == 1'b0, PRIO_INIT == 1'b1}) begin
      miscompares++;
      $display("FAIL reset_prio: got %b expected %b", {bus.req0_ready, bus.req1_ready},
               {PRIO_INIT == 1'b0, PRIO_INIT == 1'b1});
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_single();
    bus.resp_ready = 1'b1;
    drive_req(0, 1'b1, 5'b11011, 2'b00, 16'd2, 16'd3, 4'd5);
    #1;
    vectors++;
    if (bus.req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready: got %b expected 1", bus.req0_ready);
    end
    tick();
    bus.req0_valid = 1'b0;
    #1;
    vectors++;
    if ({bus.resp_valid, bus.busy, bus.alu_opcode, bus.alu_funct, bus.alu_a, bus.alu_b} !==
        {1'b0, 1'b1, 5'b11011, 2'b00, 16'd2, 16'd3}) begin
      miscompares++;
      $display("FAIL single_issue: got rv=%b busy=%b op=%b fn=%b a=%0d b=%0d", bus.resp_valid,
               bus.busy, bus.alu_opcode, bus.alu_funct, bus.alu_a, bus.alu_b);
    end
    tick();
    vectors++;
    if ({bus.resp_valid, bus.resp_data, bus.resp_id, bus.resp_tag} !== {1'b1, 16'd5, 1'b0, 4'd5}) begin
      miscompares++;
      $display("FAIL single_add: got v=%b d=%0d id=%b tag=%0d expected 1/5/0/5",
               bus.resp_valid, bus.resp_data, bus.resp_id, bus.resp_tag);
    end
    drive_req(0, 1'b1, 5'b11011, 2'b01, 16'd3, 16'd10, 4'd9);
    #1;
    vectors++;
    if (bus.req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready2: got %b expected 1", bus.req0_ready);
    end
    tick();
    bus.req0_valid = 1'b0;
    tick();
    vectors++;
    if ({bus.resp_valid, bus.resp_data, bus.resp_id, bus.resp_tag} !== {1'b1, 16'd7, 1'b0, 4'd9}) begin
      miscompares++;
      $display("FAIL single_sub: got v=%b d=%0d id=%b tag=%0d expected 1/7/0/9",
               bus.resp_valid, bus.resp_data, bus.resp_id, bus.resp_tag);
    end
    tick();
    vectors++;
    if ({bus.resp_valid, bus.busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_drain: got %b expected 00", {bus.resp_valid, bus.busy});
    end
  endtask

  task automatic test_contention();
    int sent[2];
    int last_id;
    sent[0] = 0; sent[1] = 0;
    last_id = -1;
    bus.resp_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (sent[0] == 4 && sent[1] == 4 && mq.size() == 0) break;
      for (int i = 0; i < 2; i++)
        drive_req(i, sent[i] < 4, 5'b11011, 2'(sent[i]), 16'(100 * i + sent[i]), 16'(7 + cyc),
                  4'(8 * i + sent[i]));
      #1;
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== {m_ready(0), m_ready(1)}) begin
        miscompares++;
        $display("FAIL cont_grant: got %b expected %b", {bus.req0_ready, bus.req1_ready},
                 {m_ready(0), m_ready(1)});
      end
      if (sent[0] < 4 && sent[1] < 4 && last_id >= 0) begin
        vectors++;
        if (bus.req1_ready !== (last_id == 0)) begin
          miscompares++;
          $display("FAIL cont_alternate: got req1_ready=%b after id %0d", bus.req1_ready, last_id);
        end
      end
      vectors++;
      if (bus.resp_valid !== m_resp_valid()) begin
        miscompares++;
        $display("FAIL cont_resp_valid: got %b expected %b", bus.resp_valid, m_resp_valid());
      end
      if (m_resp_valid()) begin
        vectors++;
        if ({bus.resp_data, bus.resp_id, bus.resp_tag} !== {mq[0].data, mq[0].id, mq[0].tag}) begin
          miscompares++;
          $display("FAIL cont_resp: got d=%h id=%b tag=%h expected d=%h id=%b tag=%h", bus.resp_data,
                   bus.resp_id, bus.resp_tag, mq[0].data, mq[0].id, mq[0].tag);
        end
      end
      tick();
      if (acc0) begin sent[0]++; last_id = 0; end
      if (acc1) begin sent[1]++; last_id = 1; end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    vectors++;
    if (sent[0] != 4 || sent[1] != 4 || mq.size() != 0) begin
      miscompares++;
      $display("FAIL cont_timeout: sent %0d/%0d left %0d expected 4/4/0", sent[0], sent[1], mq.size());
    end
  endtask

  task automatic test_backpressure();
    bus.resp_ready = 1'b0;
    drive_req(0, 1'b1, 5'b11011, 2'b00, 16'd100, 16'd23, 4'd1);
    #1;
    vectors++;
    if (bus.req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_accept_a: got %b expected 1", bus.req0_ready);
    end
    tick();
    drive_req(0, 1'b1, 5'b11011, 2'b01, 16'd5, 16'd50, 4'd2);
    #1;
    vectors++;
    if (bus.req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_accept_b: got %b expected 1", bus.req0_ready);
    end
    tick();
    drive_req(0, 1'b1, 5'b11011, 2'b10, 16'hF0F0, 16'h0FF0, 4'd3);
    #1;
    vectors++;
    if ({bus.req0_ready, bus.resp_valid, bus.resp_data} !== {1'b0, 1'b1, 16'd123}) begin
      miscompares++;
      $display("FAIL bp_full: got rdy=%b v=%b d=%0d expected 0/1/123", bus.req0_ready, bus.resp_valid,
               bus.resp_data);
    end
    tick();
    vectors++;
    if ({bus.req0_ready, bus.resp_data, bus.resp_tag} !== {1'b0, 16'd123, 4'd1}) begin
      miscompares++;
      $display("FAIL bp_stable: got rdy=%b d=%0d tag=%0d expected 0/123/1", bus.req0_ready,
               bus.resp_data, bus.resp_tag);
    end
    bus.resp_ready = 1'b1;
    #1;
    vectors++;
    if (bus.req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_accept_c: got %b expected 1", bus.req0_ready);
    end
    tick();
    bus.req0_valid = 1'b0;
    #1;
    vectors++;
    if ({bus.resp_valid, bus.resp_data, bus.resp_tag} !== {1'b1, 16'd45, 4'd2}) begin
      miscompares++;
      $display("FAIL bp_drain_b: got v=%b d=%0d tag=%0d expected 1/45/2", bus.resp_valid,
               bus.resp_data, bus.resp_tag);
    end
    tick();
    vectors++;
    if ({bus.resp_valid, bus.resp_data, bus.resp_tag} !== {1'b1, 16'h00F0, 4'd3}) begin
      miscompares++;
      $display("FAIL bp_drain_c: got v=%b d=%h tag=%0d expected 1/00f0/3", bus.resp_valid,
               bus.resp_data, bus.resp_tag);
    end
    tick();
    vectors++;
    if (bus.resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_empty: got %b expected 0", bus.resp_valid);
    end
  endtask

  task automatic test_pop_push();
    bus.resp_ready = 1'b1;
    drive_req(1, 1'b1, 5'b11011, 2'b11, 16'h0F00, 16'h00F0, 4'd7);
    tick();
    drive_req(1, 1'b1, 5'b00001, 2'b00, 16'h1234, 16'h0000, 4'd8);
    tick();
    drive_req(1, 1'b1, 5'b11011, 2'b00, 16'hFFFF, 16'h0001, 4'd9);
    #1;
    vectors++;
    if ({bus.req1_ready, bus.resp_valid, bus.resp_data, bus.resp_id} !== {1'b1, 1'b1, 16'h0FF0, 1'b1}) begin
      miscompares++;
      $display("FAIL pp_full: got rdy=%b v=%b d=%h id=%b expected 1/1/0ff0/1", bus.req1_ready,
               bus.resp_valid, bus.resp_data, bus.resp_id);
    end
    tick();
    bus.req1_valid = 1'b0;
    #1;
    vectors++;
    if ({bus.resp_valid, bus.resp_data, bus.resp_tag} !== {1'b1, 16'h1235, 4'd8}) begin
      miscompares++;
      $display("FAIL pp_no_bubble: got v=%b d=%h tag=%0d expected 1/1235/8", bus.resp_valid,
               bus.resp_data, bus.resp_tag);
    end
    tick();
    vectors++;
    if ({bus.resp_valid, bus.resp_data, bus.resp_tag} !== {1'b1, 16'h0000, 4'd9}) begin
      miscompares++;
      $display("FAIL pp_last: got v=%b d=%h tag=%0d expected 1/0000/9", bus.resp_valid,
               bus.resp_data, bus.resp_tag);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.resp_ready = 1'b0;
    drive_req(0, 1'b1, 5'b11011, 2'b00, 16'd1, 16'd1, 4'd1);
    tick();
    drive_req(0, 1'b1, 5'b11011, 2'b00, 16'd2, 16'd2, 4'd2);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.resp_valid} !== 2'b11) begin
      miscompares++;
      $display("FAIL rm_full: got %b expected 11", {bus.busy, bus.resp_valid});
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.resp_valid, bus.busy, bus.alu_opcode, bus.alu_a, bus.alu_b} !== '0) begin
      miscompares++;
      $display("FAIL rm_async: got v=%b busy=%b alu=%h", bus.resp_valid, bus.busy,
               {bus.alu_opcode, bus.alu_a, bus.alu_b});
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if ({bus.resp_valid, bus.busy} !== 2'b00) begin
        miscompares++;
        $display("FAIL rm_stale: cycle %0d got %b expected 00", k, {bus.resp_valid, bus.busy});
      end
    end
  endtask

  task automatic test_random();
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 60) begin
          pend[i]  = 1'b1;
          r_op[i]  = ($urandom_range(0, 1) == 1) ? 5'b11011 : 5'($urandom);
          r_fn[i]  = 2'($urandom);
          r_a[i]   = 16'($urandom);
          r_b[i]   = 16'($urandom);
          r_tag[i] = 4'($urandom);
        end
        drive_req(i, pend[i], r_op[i], r_fn[i], r_a[i], r_b[i], r_tag[i]);
      end
      bus.resp_ready = ($urandom_range(0, 99) < 65);
      #1;
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== {m_ready(0), m_ready(1)}) begin
        miscompares++;
        $display("FAIL rnd_ready: cycle %0d got %b expected %b", cyc, {bus.req0_ready, bus.req1_ready},
                 {m_ready(0), m_ready(1)});
      end
      vectors++;
      if ({bus.resp_valid, bus.busy} !== {m_resp_valid(), mq.size() > 0}) begin
        miscompares++;
        $display("FAIL rnd_valid: cycle %0d got %b expected %b", cyc, {bus.resp_valid, bus.busy},
                 {m_resp_valid(), mq.size() > 0});
      end
      if (m_resp_valid()) begin
        vectors++;
        if ({bus.resp_data, bus.resp_id, bus.resp_tag} !== {mq[0].data, mq[0].id, mq[0].tag}) begin
          miscompares++;
          $display("FAIL rnd_resp: cycle %0d got d=%h id=%b tag=%h expected d=%h id=%b tag=%h", cyc,
                   bus.resp_data, bus.resp_id, bus.resp_tag, mq[0].data, mq[0].id, mq[0].tag);
        end
      end
      tick();
      if (acc0) pend[0] = 1'b0;
      if (acc1) pend[1] = 1'b0;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 10 && mq.size() > 0; k++) tick();
    vectors++;
    if (mq.size() != 0 || bus.resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rnd_drain: left %0d resp_valid=%b expected 0/0", mq.size(), bus.resp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_pop_push();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
